// File: rtl/timer_tick_scheduler_if.sv
// Bus between the tick scheduler (master) and a registered interval-timer slave.
//
// Access semantics: tmr_chipselect marks exactly one access per cycle it is
// high; tmr_write_n low selects a write of tmr_writedata to tmr_address, high
// selects a read. There is no ready/wait signal: the slave always accepts in
// the same cycle and returns read data in tmr_readdata exactly one cycle after
// the read cycle. tmr_irq is a level that stays high until the timeout is
// cleared by a write to address 0.
interface timer_tick_scheduler_if;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;

    modport master (
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata,
        input  tmr_readdata,
        input  tmr_irq
    );

    modport slave (
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata,
        output tmr_readdata,
        output tmr_irq
    );
endinterface

// File: rtl/timer_tick_scheduler.sv
// Services interval-timer interrupts and fans each tick out to NCH software
// timer channels, each with a reload period and a remaining count.
module timer_tick_scheduler #(
    parameter int NCH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    timer_tick_scheduler_if.master tmr,
    input  logic                   cfg_wr,
    input  logic [1:0]             cfg_ch,
    input  logic [15:0]            cfg_period,
    output logic [NCH-1:0]         ch_event,
    output logic [31:0]            tick_count,
    output logic                   err_stopped,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_WR_CTRL  = 3'd1,
        S_IDLE     = 3'd2,
        S_CLR      = 3'd3,
        S_RD_STAT  = 3'd4,
        S_CHK      = 3'd5,
        S_DISPATCH = 3'd6
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] period [NCH];
    logic [15:0] count  [NCH];

    // Only the running bit of the status register matters here.
    logic unused_readdata;
    assign unused_readdata = ^{tmr.tmr_readdata[15:2], tmr.tmr_readdata[0]};

    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; irq is only looked at while idle.
    always_comb begin
        state_next = state;
        case (state)
            S_INIT:     state_next = S_WR_CTRL;
            S_WR_CTRL:  state_next = S_IDLE;
            S_IDLE:     if (tmr.tmr_irq) state_next = S_CLR;
            S_CLR:      state_next = S_RD_STAT;
            S_RD_STAT:  state_next = S_CHK;
            S_CHK:      state_next = S_DISPATCH;
            S_DISPATCH: state_next = S_IDLE;
            default:    state_next = S_INIT;
        endcase
    end

    // Bus outputs; forced idle while reset is asserted so an access in
    // flight is abandoned rather than completed.
    always_comb begin
        tmr.tmr_chipselect = 1'b0;
        tmr.tmr_write_n    = 1'b1;
        tmr.tmr_address    = 3'd0;
        tmr.tmr_writedata  = 16'h0000;
        if (reset_n) begin
            case (state)
                S_WR_CTRL: begin
                    tmr.tmr_chipselect = 1'b1;
                    tmr.tmr_write_n    = 1'b0;
                    tmr.tmr_address    = 3'd1;
                    tmr.tmr_writedata  = 16'h0001;
                end
                S_CLR: begin
                    tmr.tmr_chipselect = 1'b1;
                    tmr.tmr_write_n    = 1'b0;
                end
                S_RD_STAT: begin
                    tmr.tmr_chipselect = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Tick counter and sticky stopped-timer flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_count  <= 32'd0;
            err_stopped <= 1'b0;
        end else begin
            if (state == S_CHK && !tmr.tmr_readdata[1]) begin
                err_stopped <= 1'b1;
            end
            if (state == S_DISPATCH) begin
                tick_count <= tick_count + 32'd1;
            end
        end
    end

    // Channel periods/counts and registered expiry pulses; a config write
    // takes priority over the dispatch update of the same channel.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ch_event <= '0;
            for (int i = 0; i < NCH; i++) begin
                period[i] <= 16'd0;
                count[i]  <= 16'd0;
            end
        end else begin
            ch_event <= '0;
            for (int i = 0; i < NCH; i++) begin
                if (cfg_wr && int'(cfg_ch) == i) begin
                    period[i] <= cfg_period;
                    count[i]  <= cfg_period;
                end else if (state == S_DISPATCH && period[i] != 16'd0) begin
                    if (count[i] == 16'd1) begin
                        ch_event[i] <= 1'b1;
                        count[i]    <= period[i];
                    end else if (count[i] > 16'd1) begin
                        count[i] <= count[i] - 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/timer_tick_scheduler.md
TIMER_TICK_SCHEDULER -- requirements
Module: timer_tick_scheduler

Interface
REQ-001 SHALL have parameter NCH, default 4, number of software timer channels (fixed at 4 in this release).
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port tmr_address  output  3  register address toward the interval timer slave.
REQ-005 SHALL have port tmr_chipselect  output  1  slave select, one cycle per access.
REQ-006 SHALL have port tmr_write_n  output  1  active-low write strobe.
REQ-007 SHALL have port tmr_writedata  output  16  write data.
REQ-008 SHALL have port tmr_readdata  input  16  read data, valid exactly one cycle after the read cycle (registered slave).
REQ-009 SHALL have port tmr_irq  input  1  level timeout interrupt from the timer.
REQ-010 SHALL have port cfg_wr  input  1  one-cycle channel configuration strobe.
REQ-011 SHALL have port cfg_ch  input  2  channel index for cfg_wr.
REQ-012 SHALL have port cfg_period  input  16  channel period in ticks; 0 disables the channel.
REQ-013 SHALL have port ch_event  output  4  one-cycle expiry pulse per channel.
REQ-014 SHALL have port tick_count  output  32  total ticks serviced.
REQ-015 SHALL have port err_stopped  output  1  sticky flag: timer reported not running.

Function
REQ-016 SHALL implement FSM states INIT, WR_CTRL, IDLE, CLR, RD_STAT, CHK, DISPATCH.
REQ-017 INIT SHALL last one cycle and then go to WR_CTRL.
REQ-018 WR_CTRL SHALL drive chipselect=1, write_n=0, address=1, writedata=16'h0001 (IRQ enable) for one cycle, then go to IDLE.
REQ-019 IDLE with tmr_irq=1 SHALL go to CLR; otherwise it SHALL remain in IDLE.
REQ-020 CLR SHALL write address 0 (data 0) for one cycle to clear timeout, then go to RD_STAT.
REQ-021 RD_STAT SHALL drive chipselect=1, write_n=1, address=0 for one cycle, then go to CHK.
REQ-022 CHK SHALL sample tmr_readdata; if bit1 (running)=0 it SHALL set err_stopped, and it SHALL go to DISPATCH in either case.
REQ-023 DISPATCH SHALL last one cycle, increment tick_count (wrap 32'hFFFFFFFF->0), update all channels in parallel, then go to IDLE.
REQ-024 In every state other than WR_CTRL, CLR and RD_STAT, outputs SHALL be chipselect=0, write_n=1, address=0, writedata=0.
REQ-025 Each channel SHALL hold a 16-bit period and a 16-bit remaining count.
REQ-026 cfg_wr SHALL load period[cfg_ch] and count[cfg_ch] with cfg_period on the next edge.
REQ-027 In DISPATCH, a channel with period!=0 and count==1 SHALL pulse ch_event for that cycle's registered output and reload count=period.
REQ-028 In DISPATCH, a channel with period!=0 and count>1 SHALL decrement count by 1.
REQ-029 A channel with period==0 SHALL never pulse and never change count.
REQ-030 Period 1 SHALL fire on every tick.
REQ-031 If cfg_wr targets a channel in its DISPATCH cycle, the configuration write SHALL win and no event SHALL fire for that channel.
REQ-032 ch_event SHALL be registered: pulses appear the cycle after DISPATCH and last exactly one cycle.
REQ-033 Minimum service latency from tmr_irq rising in IDLE to ch_event SHALL be 5 cycles.
REQ-034 tmr_irq asserting in states other than IDLE SHALL be ignored until the FSM returns to IDLE; the level is then serviced.

Reset
REQ-035 With reset_n=0 at a clock edge, the block SHALL enter INIT and clear tick_count, err_stopped, ch_event, and all periods and counts to 0.
REQ-036 During reset, bus outputs SHALL be chipselect=0, write_n=1, address=0, writedata=0; reset mid-service SHALL abort without completing the pending access.

Verification
REQ-037 Release reset -> one write cycle at address 1 with data 0x0001 occurs on cycle 2 after release; then idle bus.
REQ-038 cfg ch0 period 3, then 6 irq services -> ch_event[0] pulses after services 3 and 6; tick_count=6.
REQ-039 ch1 period 1 plus ch2 period 0 -> ch1 pulses on every service; ch2 never pulses.
REQ-040 readdata bit1=0 in CHK -> err_stopped=1 and remains 1 until reset; dispatch still occurs.
REQ-041 cfg_wr to ch0 (count==1) in its DISPATCH cycle with period 5 -> no pulse; fires 5 services later.
REQ-042 reset_n low during CLR -> bus idle next cycle; after release, re-runs INIT/WR_CTRL; tick_count=0.
